// File: rtl/bram_rd_arbiter_if.sv
// ----------------------------------------------------------------------------
// bram_rd_arbiter_if
// Purpose : bundles the requester handshake, response and BRAM read-port
//           signals of bram_rd_arbiter.
// Signals : req_valid/req_addr/req_ready  requester read handshake
//           rsp_valid/rsp_data/rsp_err    one-hot response strobe + shared word
//           bram_ena/bram_addr/bram_dout  BRAM port A (ena, addra, douta)
//           grant_cnt                     accepted-request counter
// Modports: slave  - arbiter side
//           master - requesters + BRAM side
// ----------------------------------------------------------------------------
interface bram_rd_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          rsp_err;
    logic                          bram_ena;
    logic [ADDR_WIDTH-1:0]         bram_addr;
    logic [DATA_WIDTH-1:0]         bram_dout;
    logic [31:0]                   grant_cnt;

    modport slave (
        input  req_valid, req_addr, bram_dout,
        output req_ready, rsp_valid, rsp_data, rsp_err, bram_ena, bram_addr, grant_cnt
    );

    modport master (
        output req_valid, req_addr, bram_dout,
        input  req_ready, rsp_valid, rsp_data, rsp_err, bram_ena, bram_addr, grant_cnt
    );
endinterface

// File: rtl/bram_rd_arbiter.sv
// ----------------------------------------------------------------------------
// bram_rd_arbiter
// Purpose : round-robin arbiter sharing one synchronous BRAM read port among
//           NUM_REQ requesters; routes each returned word to its issuer, flags
//           out-of-range addresses and counts grants.
// Ports   : clka   - clock shared with the BRAM
//           rsta_n - synchronous active-low reset
//           bus    - bram_rd_arbiter_if.slave (requests, responses, BRAM port,
//                    grant counter)
// Option  : BRAM_ARB_OUTREG_EN - adds one register stage on rsp_valid,
//           rsp_data and rsp_err (read latency 2 instead of 1).
// ----------------------------------------------------------------------------
module bram_rd_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16384
) (
    input logic              clka,
    input logic              rsta_n,
    bram_rd_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 32;

    logic [PTR_W-1:0]      r_rr_ptr;
    logic [NUM_REQ-1:0]    r_tag_q;
    logic                  r_err_q;
    logic [CNT_W-1:0]      r_grant_cnt;

    logic [NUM_REQ-1:0]    w_grant;
    logic [PTR_W-1:0]      w_gidx;
    logic [PTR_W-1:0]      w_k;
    logic                  w_found;
    logic [ADDR_WIDTH-1:0] w_gaddr;
    logic                  w_in_range;
    logic [NUM_REQ-1:0]    w_rsp_valid;
    logic [DATA_WIDTH-1:0] w_rsp_data;
    logic                  w_rsp_err;
    logic [NUM_REQ-1:0]    w_out_valid;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic                  w_out_err;

    // Round-robin pick: first valid index scanning from r_rr_ptr; nothing granted in reset.
    always_comb begin : rr_pick
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            w_k = PTR_W'((32'(r_rr_ptr) + 32'(j)) % NUM_REQ);
            if (!w_found && rsta_n && bus.req_valid[w_k]) begin
                w_found      = 1'b1;
                w_grant[w_k] = 1'b1;
                w_gidx       = w_k;
            end
        end
    end

    // Address of the granted requester (one-hot OR mux).
    always_comb begin : addr_mux
        w_gaddr = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_grant[i]) begin
                w_gaddr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign w_in_range    = (w_gaddr < ADDR_WIDTH'(DEPTH));
    assign bus.req_ready = w_grant;
    assign bus.bram_ena  = w_found & w_in_range;
    assign bus.bram_addr = (w_found && w_in_range) ? w_gaddr : '0;
    assign bus.grant_cnt = r_grant_cnt;

    // Pointer, in-flight tag/err pipeline and grant counter.
    always_ff @(posedge clka) begin : arb_state
        if (!rsta_n) begin
            r_rr_ptr    <= '0;
            r_tag_q     <= '0;
            r_err_q     <= 1'b0;
            r_grant_cnt <= '0;
        end else begin
            r_tag_q <= w_grant;
            r_err_q <= w_found & ~w_in_range;
            if (w_found) begin
                r_rr_ptr    <= (32'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + PTR_W'(1);
                r_grant_cnt <= r_grant_cnt + CNT_W'(1);
            end
        end
    end

    // Out-of-range reads never touched the BRAM, so their word is forced to zero.
    assign w_rsp_valid = r_tag_q;
    assign w_rsp_err   = r_err_q;
    assign w_rsp_data  = (|r_tag_q && !r_err_q) ? bus.bram_dout : '0;

`ifdef BRAM_ARB_OUTREG_EN
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;

    // Extra response register stage.
    always_ff @(posedge clka) begin : rsp_outreg
        if (!rsta_n) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_rsp_err   <= w_rsp_err;
        end
    end

    assign w_out_valid = r_rsp_valid;
    assign w_out_data  = r_rsp_data;
    assign w_out_err   = r_rsp_err;
`else
    assign w_out_valid = w_rsp_valid;
    assign w_out_data  = w_rsp_data;
    assign w_out_err   = w_rsp_err;
`endif

    // Masked while rsta_n is low so an in-flight response never appears once reset is asserted.
    assign bus.rsp_valid = w_out_valid & {NUM_REQ{rsta_n}};
    assign bus.rsp_data  = w_out_data & {DATA_WIDTH{rsta_n}};
    assign bus.rsp_err   = w_out_err & rsta_n;

endmodule

// File: tb/tb_bram_rd_arbiter.sv
`timescale 1ns/1ps
module tb_bram_rd_arbiter;
    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned DEPTH      = 16384;
`ifdef BRAM_ARB_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clka   = 1'b0;
    logic rsta_n = 1'b0;
    always #5 clka = ~clka;

    bram_rd_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    bram_rd_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)
    ) dut (
        .clka   (clka),
        .rsta_n (rsta_n),
        .bus    (bus)
    );

    logic [3:0]   drv_valid = '0;
    logic [127:0] drv_addr  = '0;
    logic [31:0]  bram_q    = '0;

    assign bus.req_valid = drv_valid;
    assign bus.req_addr  = drv_addr;
    assign bus.bram_dout = bram_q;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   model_ptr = 0;

    // BRAM contents: 0x10 holds 0xDEADBEEF, everything else an address-derived pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    always @(posedge clka) if (bus.bram_ena) bram_q <= mem_word(bus.bram_addr);

    task automatic set_req(input int i, input logic v, input logic [31:0] a);
        drv_valid[i]          = v;
        drv_addr[i*32 +: 32]  = a;
    endtask

    // Scoreboard/monitor: reference round-robin model pushes expectations, responses pop them.
    initial begin : monitor
        exp_t        e;
        int          w;
        int          k;
        logic [3:0]  exp_rdy;
        logic [31:0] a;
        forever begin
            @(negedge clka);
            #2;
            if (bus.rsp_valid != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected rsp_valid=%b with nothing outstanding", bus.rsp_valid);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rsp_valid !== 4'(1 << e.idx) || bus.rsp_data !== e.data || bus.rsp_err !== e.err) begin
                        failures++;
                        $display("FAIL sb_rsp got valid=%b data=%h err=%b expected valid=%b data=%h err=%b",
                                 bus.rsp_valid, bus.rsp_data, bus.rsp_err, 4'(1 << e.idx), e.data, e.err);
                    end
                end
            end
            w = -1;
            if (rsta_n) begin
                for (int j = 0; j < 4; j++) begin
                    k = (model_ptr + j) % 4;
                    if (w < 0 && drv_valid[k]) w = k;
                end
            end
            exp_rdy = (w >= 0) ? 4'(1 << w) : 4'b0000;
            if (drv_valid != '0 || bus.req_ready != '0) begin
                checks++;
                if (bus.req_ready !== exp_rdy) begin
                    failures++;
                    $display("FAIL arb_ready got %b expected %b (valid=%b ptr=%0d)", bus.req_ready, exp_rdy, drv_valid, model_ptr);
                end
            end
            if (w >= 0) begin
                a      = drv_addr[w*32 +: 32];
                e.idx  = w;
                e.err  = (a >= DEPTH);
                e.data = e.err ? 32'h0 : mem_word(a);
                exp_q.push_back(e);
                model_ptr = (w + 1) % 4;
            end
            if (!rsta_n) model_ptr = 0;
        end
    end

    task automatic do_reset();
        @(negedge clka);
        rsta_n    = 1'b0;
        drv_valid = '0;
        repeat (2) @(negedge clka);
        exp_q.delete();
        rsta_n = 1'b1;
    endtask

    task automatic drain(input string name);
        repeat (LAT + 1) @(negedge clka);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain outstanding=%0d expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clka);
        rsta_n    = 1'b0;
        drv_valid = 4'b1111;
        repeat (2) begin
            @(negedge clka);
            #1;
            checks++;
            if (bus.req_ready !== 4'b0 || bus.bram_ena !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready got ready=%b ena=%b expected 0000/0", bus.req_ready, bus.bram_ena);
            end
            checks++;
            if (bus.rsp_valid !== 4'b0 || bus.rsp_data !== 32'h0 || bus.rsp_err !== 1'b0 || bus.grant_cnt !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs got valid=%b data=%h err=%b cnt=%h expected all 0",
                         bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.grant_cnt);
            end
        end
        @(negedge clka);
        drv_valid = '0;
        exp_q.delete();
        rsta_n = 1'b1;
        @(negedge clka);
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b0 || bus.rsp_data !== 32'h0 || bus.grant_cnt !== 32'h0) begin
            failures++;
            $display("FAIL reset_after got valid=%b data=%h cnt=%h expected 0", bus.rsp_valid, bus.rsp_data, bus.grant_cnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clka);
        set_req(2, 1'b1, 32'h10);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100 || bus.bram_ena !== 1'b1 || bus.bram_addr !== 32'h10) begin
            failures++;
            $display("FAIL single_grant got ready=%b ena=%b addr=%h expected 0100/1/00000010",
                     bus.req_ready, bus.bram_ena, bus.bram_addr);
        end
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clka);
            if (c == 1) set_req(2, 1'b0, 32'h0);
            #1;
            if (c < LAT) begin
                checks++;
                if (bus.rsp_valid !== 4'b0) begin
                    failures++;
                    $display("FAIL single_early got rsp_valid=%b expected 0000", bus.rsp_valid);
                end
            end else begin
                checks++;
                if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 32'hDEAD_BEEF || bus.rsp_err !== 1'b0) begin
                    failures++;
                    $display("FAIL single_rsp got valid=%b data=%h err=%b expected 0100/deadbeef/0",
                             bus.rsp_valid, bus.rsp_data, bus.rsp_err);
                end
                checks++;
                if (bus.grant_cnt !== 32'd1) begin
                    failures++;
                    $display("FAIL single_cnt got %0d expected 1", bus.grant_cnt);
                end
            end
        end
        drain("single");
    endtask

    task automatic test_fairness();
        do_reset();
        @(negedge clka);
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'h100 + 32'(i));
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clka);
            #1;
            checks++;
            if (bus.req_ready !== 4'(1 << (c % 4)) || bus.bram_addr !== 32'h100 + 32'(c % 4)) begin
                failures++;
                $display("FAIL fair_grant cycle %0d got ready=%b addr=%h expected %b/%h",
                         c, bus.req_ready, bus.bram_addr, 4'(1 << (c % 4)), 32'h100 + 32'(c % 4));
            end
        end
        @(negedge clka);
        drv_valid = '0;
        drain("fair");
        checks++;
        if (bus.grant_cnt !== 32'd8) begin
            failures++;
            $display("FAIL fair_cnt got %0d expected 8", bus.grant_cnt);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        @(negedge clka);
        set_req(1, 1'b1, DEPTH);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010 || bus.bram_ena !== 1'b0) begin
            failures++;
            $display("FAIL oor_grant got ready=%b ena=%b expected 0010/0", bus.req_ready, bus.bram_ena);
        end
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clka);
            if (c == 1) set_req(1, 1'b0, 32'h0);
        end
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'h0) begin
            failures++;
            $display("FAIL oor_rsp got valid=%b err=%b data=%h expected 0010/1/0", bus.rsp_valid, bus.rsp_err, bus.rsp_data);
        end
        @(negedge clka);
        set_req(1, 1'b1, DEPTH - 1);
        #1;
        checks++;
        if (bus.bram_ena !== 1'b1 || bus.bram_addr !== 32'(DEPTH - 1)) begin
            failures++;
            $display("FAIL edge_addr got ena=%b addr=%h expected 1/%h", bus.bram_ena, bus.bram_addr, 32'(DEPTH - 1));
        end
        @(negedge clka);
        set_req(1, 1'b0, 32'h0);
        drain("oor");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clka);
            set_req(0, 1'b1, 32'h20 + 32'(c));
            #1;
            checks++;
            if (bus.req_ready !== 4'b0001 || bus.bram_addr !== 32'h20 + 32'(c)) begin
                failures++;
                $display("FAIL b2b_grant cycle %0d got ready=%b addr=%h expected 0001/%h",
                         c, bus.req_ready, bus.bram_addr, 32'h20 + 32'(c));
            end
        end
        @(negedge clka);
        drv_valid = '0;
        drain("b2b");
    endtask

    task automatic test_reset_midflight();
        do_reset();
        @(negedge clka);
        set_req(3, 1'b1, 32'h30);
        @(posedge clka);
        #1;
        rsta_n    = 1'b0;
        drv_valid = '0;
        exp_q.delete();
        repeat (3) begin
            @(negedge clka);
            #1;
            checks++;
            if (bus.rsp_valid !== 4'b0) begin
                failures++;
                $display("FAIL midrst_rsp got rsp_valid=%b expected 0000", bus.rsp_valid);
            end
        end
        checks++;
        if (bus.grant_cnt !== 32'h0) begin
            failures++;
            $display("FAIL midrst_cnt got %0d expected 0", bus.grant_cnt);
        end
        @(negedge clka);
        rsta_n = 1'b1;
        @(negedge clka);
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'h40 + 32'(i));
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL midrst_ptr got ready=%b expected 0001", bus.req_ready);
        end
        @(negedge clka);
        drv_valid = '0;
        drain("midrst");
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clka);
        force dut.r_grant_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_grant_cnt;
        #1;
        checks++;
        if (bus.grant_cnt !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL wrap_preset got %h expected ffffffff", bus.grant_cnt);
        end
        @(negedge clka);
        set_req(0, 1'b1, 32'h5);
        @(negedge clka);
        set_req(0, 1'b0, 32'h0);
        #1;
        checks++;
        if (bus.grant_cnt !== 32'h0) begin
            failures++;
            $display("FAIL wrap_cnt got %h expected 00000000", bus.grant_cnt);
        end
        drain("wrap");
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0:       return 32'(DEPTH - 1);
            1:       return 32'(DEPTH);
            2:       return 32'($urandom_range(DEPTH + 1, 40000));
            default: return 32'($urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    task automatic test_random();
        logic [3:0] granted;
        granted = '0;
        do_reset();
        for (int c = 0; c < 80; c++) begin
            @(negedge clka);
            for (int i = 0; i < 4; i++) begin
                if (drv_valid[i] && !granted[i]) begin
                    if ($urandom_range(0, 3) == 0) set_req(i, 1'b0, 32'h0);
                end else if ($urandom_range(0, 1) == 1) begin
                    set_req(i, 1'b1, pick_addr());
                end else begin
                    set_req(i, 1'b0, 32'h0);
                end
            end
            #1;
            granted = bus.req_ready;
        end
        @(negedge clka);
        drv_valid = '0;
        drain("random");
    endtask

    initial begin : main
        test_reset();
        test_single();
        test_fairness();
        test_out_of_range();
        test_back_to_back();
        test_reset_midflight();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bram_rd_arbiter.md
# bram_rd_arbiter

Round-robin read arbiter that shares the single synchronous read port of one classifier BRAM (the per-classifier ROM, one-cycle registered read) among `NUM_REQ` tree-traversal requesters. It accepts at most one read per cycle and drives the BRAM `ena`/`addra`. It routes the returned `douta` word back to the requester that issued it, tags out-of-range addresses, and keeps a grant counter for throughput measurement. It sits between the traversal engines and the classifier BRAM inside each classifier slice.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ADDR_WIDTH`, 32: address width, matches BRAM.
- `DATA_WIDTH`, 32: data width, matches BRAM.
- `DEPTH`, 16384: BRAM word count; legal addresses are 0..DEPTH-1.

- `clka` in 1: clock; the BRAM shares this clock.
- `rsta_n` in 1: reset. One clock; reset is synchronous and active-low.
- `req_valid` in NUM_REQ: per-requester read request.
- `req_addr` in NUM_REQ*ADDR_WIDTH: requester i's address in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_ready` out NUM_REQ: one-hot accept, combinational from `req_valid` and the priority pointer.
- `rsp_valid` out NUM_REQ: one-hot response strobe.
- `rsp_data` out DATA_WIDTH: response word, shared by all requesters.
- `rsp_err` out 1: response belongs to an out-of-range address.
- `bram_ena` out 1: to BRAM `ena`.
- `bram_addr` out ADDR_WIDTH: to BRAM `addra`.
- `bram_dout` in DATA_WIDTH: from BRAM `douta`.
- `grant_cnt` out 32: number of accepted requests; wraps modulo 2^32.

## Operation
- Handshake: a transfer occurs on a rising edge where `req_valid[i] && req_ready[i]`. A requester holds `req_valid` and `req_addr` stable until accepted. Dropping `req_valid` before acceptance is legal; the request is abandoned.
- Arbitration is round-robin. Pointer `rr_ptr` (log2 NUM_REQ bits) marks the highest-priority index. The winner is the first valid index scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- After a grant to index k, `rr_ptr` ← (k+1) mod NUM_REQ. With no grant, `rr_ptr` holds.
- There is no backpressure on responses. A request is accepted every cycle that any `req_valid` is high.
- Granted address in range (< DEPTH):
  - `bram_ena`=1 and `bram_addr`=granted address, both combinational in the grant cycle.
- Granted address ≥ DEPTH:
  - `bram_ena`=0; the BRAM is not read.
  - The response still returns: `rsp_data`=0 and `rsp_err`=1.
- With no grant, `bram_ena`=0 and `bram_addr`=0.
- In-flight tracking uses pipeline registers `tag_q` (one-hot NUM_REQ) and `err_q`, loaded on every edge: the grant vector or zero.
- `grant_cnt` increments by 1 per accepted request. The full-count value 0xFFFF_FFFF wraps to 0.
- Reset (`rsta_n`=0 at an edge) clears:
  - `rr_ptr`=0, `tag_q`=0, `err_q`=0, `grant_cnt`=0.
  - Any output-register stage.
  - Responses in flight are discarded, and no `rsp_valid` fires for them after reset.
- Outputs under reset and after it:
  - `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0, `grant_cnt`=0.
  - `req_ready` and `bram_ena` are 0 while `rsta_n`=0.

## Timing
- The accept cycle is T, meaning the transfer occurs on edge T.
- Base build: `rsp_valid[i]`=1 for exactly one cycle, in cycle T+1.
  - `rsp_data` = `bram_dout` (or 0 if err).
  - Read latency is 1 cycle.
- Back-to-back grants give one response per cycle, in issue order. Peak throughput is 1 read/cycle.
- Simultaneous events:
  - A new grant and the previous grant's response occur in the same cycle. Both are legal and independent.
  - The same requester may be granted in consecutive cycles if it is the only one requesting.
- `rsp_data` is don't-care when `rsp_valid`=0, except during and after reset, when it is 0.

## Configuration
- `BRAM_ARB_OUTREG_EN`:
  - Defined: `rsp_valid`, `rsp_data` and `rsp_err` pass through one extra register stage (reset to 0). Latency becomes 2 cycles (response in T+2), and throughput is unchanged.
  - Undefined: latency is 1, as above.

## Test plan
- Single request: requester 2 reads address 0x10 (BRAM preloaded 0x10→0xDEADBEEF).
  - Same cycle: `req_ready`=4'b0100, `bram_ena`=1, `bram_addr`=0x10.
  - Next cycle: `rsp_valid`=4'b0100, `rsp_data`=0xDEADBEEF, `grant_cnt`=1.
- Fairness: all four requesters hold `req_valid` for 8 cycles from reset.
  - Grants go 0,1,2,3,0,1,2,3.
  - Responses follow in the same order, one per cycle.
  - `grant_cnt`=8.
- Out of range: requester 1 reads address 16384.
  - `bram_ena`=0 in the grant cycle.
  - Next cycle: `rsp_valid`=4'b0010, `rsp_err`=1, `rsp_data`=0.
- Reset mid-flight: grant to requester 3, then `rsta_n`=0 on the following edge.
  - No `rsp_valid` is ever seen.
  - `grant_cnt`=0 and `rr_ptr`=0; the next grant goes to requester 0 when all request.
- Wrap: force `grant_cnt` to 0xFFFF_FFFF, then one grant → `grant_cnt`=0.
- With `BRAM_ARB_OUTREG_EN` defined: repeat the single-request test. The response appears in T+2 with identical data, and `rsp_valid` is 0 in T+1.
